param_memory: RTL

//  Parametrised single-port word memory that replaces the fixed 8x32 data store.
//  - Width and depth are configurable; writes support byte enables.
//  - Reads are registered with a one-cycle valid strobe; the output is never tri-stated.
//  - On reset, a hardware clear sequencer fills every word with INIT_VALUE; no file load.
//  - Sits beside the datapath/controller as its data memory; the controller must wait for busy=0.

---
 rtl/param_memory.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/param_memory.sv
// param_memory: single-port word memory with byte-enable writes, registered
// reads with a one-cycle valid strobe, and a post-reset hardware clear that
// fills every word with INIT_VALUE before any request is served.
module param_memory #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DEPTH      = 8,
  parameter int unsigned       ADDR_W     = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter bit                RDW_MODE   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   datai,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic                read,
  output logic [DATA_W-1:0]   datao,
  output logic                valid,
  output logic                busy,
  output logic                err
);

  localparam int unsigned       BE_W     = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptr_d;
  logic [DATA_W-1:0]   datao_d;
  logic                valid_d;
  logic                busy_d;
  logic                err_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range_c;
  logic [ADDR_W-1:0]   rd_idx_c;
  logic [DATA_W-1:0]   old_word_c;
  logic [DATA_W-1:0]   merged_c;
  logic                mem_we_c;
  logic [ADDR_W-1:0]   mem_addr_c;
  logic [DATA_W-1:0]   mem_wdata_c;

  // Address decode; out-of-range addresses read a safe index so the array is never over-indexed
  always_comb begin
    in_range_c = ({1'b0, addr} < DEPTH_V);
    rd_idx_c   = in_range_c ? addr : '0;
    old_word_c = mem[rd_idx_c];
  end

  // Byte-enable merge of the incoming write data over the current word
  for (genvar g = 0; g < BE_W; g++) begin : g_merge
    assign merged_c[8*g +: 8] = be[g] ? datai[8*g +: 8] : old_word_c[8*g +: 8];
  end

  // Next-state, memory write port and next output values
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    datao_d     = datao;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    busy_d      = busy;
    mem_we_c    = 1'b0;
    mem_addr_c  = ptr;
    mem_wdata_c = INIT_VALUE;

    case (state)
      CLEAR: begin
        busy_d      = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = ptr;
        mem_wdata_c = INIT_VALUE;
        ptr_d       = ptr + ADDR_W'(1);
        if (ptr == LAST_PTR) begin
          state_d = READY;
          busy_d  = 1'b0;
          ptr_d   = '0;
        end
      end
      READY: begin
        busy_d = 1'b0;
        if (!in_range_c) begin
          // Out-of-range: drop the write, return zero for a read, flag the request
          err_d = we | read;
          if (read) begin
            valid_d = 1'b1;
            datao_d = '0;
          end
        end else begin
          if (we) begin
            mem_we_c    = 1'b1;
            mem_addr_c  = addr;
            mem_wdata_c = merged_c;
          end
          if (read) begin
            valid_d = 1'b1;
            datao_d = (RDW_MODE && we) ? merged_c : old_word_c;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset that restarts the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
      datao <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b1;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      datao <= datao_d;
      valid <= valid_d;
      err   <= err_d;
      busy  <= busy_d;
    end
  end

  // Storage array; reset cycle suppresses any write
  always_ff @(posedge clk) begin
    if (!rst && mem_we_c) begin
      mem[mem_addr_c] <= mem_wdata_c;
    end
  end

endmodule
